// File: rtl/trachtenberg_sched_pkg.sv
// Shared constants and state encoding for the Trachtenberg multiplier scheduler.
package trachtenberg_pkg;

    localparam int W           = 5;
    localparam int LAT_DEFAULT = 10;
    localparam int PROD_W      = 2 * W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/trachtenberg_sched_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
module rr_pick #(
    parameter int  NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [NREQ-1:0] rot;
    logic [IW-1:0]   off;
    logic [IW:0]     sum;

    always_comb begin
        // rotate so that bit 0 is the client at ptr; lowest set bit is the winner
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW + 1)'(NREQ)) sum = sum - (IW + 1)'(NREQ);
        idx = sum[IW-1:0];
        any = |req;
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/trachtenberg_sched.sv
// Round-robin scheduler sharing one non-pipelined multiplier core between NREQ clients.
module trachtenberg_sched
    import trachtenberg_pkg::*;
#(
    parameter int  NREQ = 4,
    parameter int  W    = trachtenberg_pkg::W,
    parameter int  LAT  = LAT_DEFAULT,
    localparam int IW   = $clog2(NREQ),
    localparam int CW   = $clog2(LAT + 1)
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic [NREQ-1:0]   ireq,
    input  logic [NREQ*W-1:0] ia,
    input  logic [NREQ*W-1:0] ib,
    output logic [NREQ-1:0]   ogrant,
    output logic              obusy,
    output logic [2*W-1:0]    ores,
    output logic [IW-1:0]     oid,
    output logic              ovalid,
    output logic              ocore_start,
    output logic [W-1:0]      ocore_a,
    output logic [W-1:0]      ocore_b,
    input  logic [2*W-1:0]    icore_res
);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur_id;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] pk_gnt;
    logic [IW-1:0]   pk_idx;
    logic            pk_any;
    logic [W-1:0]    win_a;
    logic [W-1:0]    win_b;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (ireq),
        .ptr (ptr),
        .gnt (pk_gnt),
        .idx (pk_idx),
        .any (pk_any)
    );

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pk_gnt[k]) begin
                win_a = win_a | ia[k*W +: W];
                win_b = win_b | ib[k*W +: W];
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cur_id      <= '0;
            cnt         <= '0;
            ogrant      <= '0;
            obusy       <= 1'b0;
            ores        <= '0;
            oid         <= '0;
            ovalid      <= 1'b0;
            ocore_start <= 1'b0;
            ocore_a     <= '0;
            ocore_b     <= '0;
        end else begin
            ogrant      <= '0;
            ocore_start <= 1'b0;
            ovalid      <= 1'b0;
            case (state)
                WAIT: begin
                    // cnt holds while start is out, so capture lands LAT edges after the core samples it
                    if (!ocore_start) begin
                        if (cnt == CW'(1)) begin
                            ores  <= icore_res;
                            oid   <= cur_id;
                            ovalid <= 1'b1;
                            obusy <= 1'b0;
                            state <= DONE;
                        end
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (pk_any) begin
                        ocore_a     <= win_a;
                        ocore_b     <= win_b;
                        ocore_start <= 1'b1;
                        ogrant      <= pk_gnt;
                        cur_id      <= pk_idx;
                        ptr         <= (pk_idx == IW'(NREQ - 1)) ? '0 : pk_idx + 1'b1;
                        cnt         <= CW'(LAT);
                        obusy       <= 1'b1;
                        state       <= WAIT;
                    end else begin
                        obusy <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trachtenberg_sched.sv
// Randomised and directed bench for trachtenberg_sched; two configurations run side by side.
module tb_trachtenberg_sched;

    localparam int W = 5;

    logic iclk = 1'b0;
    always #5 iclk = ~iclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int NR = (g == 0) ? 4 : 2;
        localparam int LT = (g == 0) ? 10 : 1;
        localparam int IW = $clog2(NR);

        logic            irst_n = 1'b0;
        logic [NR-1:0]   ireq   = '0;
        logic [NR*W-1:0] ia     = '0;
        logic [NR*W-1:0] ib     = '0;
        logic [NR-1:0]   ogrant;
        logic            obusy, ovalid, ocore_start;
        logic [2*W-1:0]  ores;
        logic [2*W-1:0]  icore_res = '0;
        logic [IW-1:0]   oid;
        logic [W-1:0]    ocore_a, ocore_b;
        bit              done_f = 1'b0;

        trachtenberg_sched #(.NREQ(NR), .W(W), .LAT(LT)) dut (
            .iclk        (iclk),
            .irst_n      (irst_n),
            .ireq        (ireq),
            .ia          (ia),
            .ib          (ib),
            .ogrant      (ogrant),
            .obusy       (obusy),
            .ores        (ores),
            .oid         (oid),
            .ovalid      (ovalid),
            .ocore_start (ocore_start),
            .ocore_a     (ocore_a),
            .ocore_b     (ocore_b),
            .icore_res   (icore_res)
        );

        // core: output is junk until LAT edges after it sampled start
        int cc = 0;
        always @(posedge iclk) begin
            if (ocore_start) begin
                cc = LT - 1;
                if (cc == 0) icore_res <= ocore_a * ocore_b;
                else         icore_res <= (2*W)'($urandom);
            end else if (cc > 0) begin
                cc = cc - 1;
                if (cc == 0) icore_res <= ocore_a * ocore_b;
                else         icore_res <= (2*W)'($urandom);
            end
        end

        // reference: issue-time and capture-time bookkeeping in absolute edges
        int             m_ptr = 0, m_cap = 0, m_edge = 0, w = 0;
        bit             m_fly = 1'b0;
        logic [NR-1:0]  e_gnt;
        bit             e_start, e_valid;
        logic [W-1:0]   e_a, e_b;
        logic [2*W-1:0] e_res;
        int             e_id;

        always @(posedge iclk or negedge irst_n) begin
            if (!irst_n) begin
                m_ptr = 0; m_fly = 1'b0; w = 0;
                e_gnt = '0; e_start = 1'b0; e_valid = 1'b0;
                e_a = '0; e_b = '0; e_res = '0; e_id = 0;
            end else begin
                m_edge++;
                e_gnt = '0; e_start = 1'b0; e_valid = 1'b0;
                if (m_fly) begin
                    if (m_edge == m_cap) begin
                        e_valid = 1'b1;
                        e_res   = e_a * e_b;
                        e_id    = w;
                        m_fly   = 1'b0;
                    end
                end else if (ireq != '0) begin
                    w = m_ptr;
                    while (!ireq[w]) w = (w + 1) % NR;
                    e_gnt[w] = 1'b1;
                    e_start  = 1'b1;
                    e_a      = ia[w*W +: W];
                    e_b      = ib[w*W +: W];
                    m_ptr    = (w + 1) % NR;
                    m_fly    = 1'b1;
                    m_cap    = m_edge + LT + 1;
                end
            end
        end

        always @(negedge iclk) begin
            chk($sformatf("c%0d ogrant", g),      64'(ogrant),      64'(e_gnt));
            chk($sformatf("c%0d ocore_start", g), 64'(ocore_start), 64'(e_start));
            chk($sformatf("c%0d obusy", g),       64'(obusy),       64'(m_fly));
            chk($sformatf("c%0d ovalid", g),      64'(ovalid),      64'(e_valid));
            chk($sformatf("c%0d ocore_a", g),     64'(ocore_a),     64'(e_a));
            chk($sformatf("c%0d ocore_b", g),     64'(ocore_b),     64'(e_b));
            chk($sformatf("c%0d ores", g),        64'(ores),        64'(e_res));
            chk($sformatf("c%0d oid", g),         64'(oid),         64'(e_id));
        end

        // event log for the directed checks
        int             cyc = 0;
        int             g_idx[$], g_t[$], v_t[$], v_id[$];
        logic [2*W-1:0] v_res[$];

        always @(posedge iclk) cyc++;
        always @(negedge iclk) begin
            for (int k = 0; k < NR; k++) begin
                if (ogrant[k]) begin
                    g_idx.push_back(k);
                    g_t.push_back(cyc);
                end
            end
            if (ovalid) begin
                v_t.push_back(cyc);
                v_id.push_back(int'(oid));
                v_res.push_back(ores);
            end
        end

        task automatic clr_log();
            g_idx.delete(); g_t.delete(); v_t.delete(); v_id.delete(); v_res.delete();
        endtask

        task automatic tick(input bit rnd, input logic [NR-1:0] keep);
            @(posedge iclk);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (ogrant[k] && !keep[k]) ireq[k] = 1'b0;
                if (rnd) begin
                    if (!ireq[k] && $urandom_range(0, 3) == 0) begin
                        ia[k*W +: W] = W'($urandom);
                        ib[k*W +: W] = W'($urandom);
                        ireq[k] = 1'b1;
                    end else if (ireq[k] && $urandom_range(0, 24) == 0) begin
                        ireq[k] = 1'b0;
                    end
                end
            end
        endtask

        task automatic req(input int k, input int a, input int b);
            ia[k*W +: W] = W'(a);
            ib[k*W +: W] = W'(b);
            ireq[k] = 1'b1;
        endtask

        task automatic do_reset();
            ireq = '0;
            tick(0, '0);
            irst_n = 1'b0;
            tick(0, '0);
            tick(0, '0);
            irst_n = 1'b1;
            clr_log();
        endtask

        task automatic wait_valid(input int n, input int bound, input logic [NR-1:0] keep, input string tag);
            int i;
            i = 0;
            while (v_t.size() < n && i < bound) begin
                tick(0, keep);
                i++;
            end
            if (v_t.size() < n) chk($sformatf("c%0d %s timeout", g, tag), 64'(v_t.size()), 64'(n));
        endtask

        initial begin
            int exp_g[5];
            int exp_r[5];
            int zeros;
            exp_g = '{0, 1, 2, 3, 0};
            exp_r = '{961, 1, 0, 30, 961};
            repeat (2) @(posedge iclk);
            #1 irst_n = 1'b1;
            if (g == 0) begin
                // single request, client 2
                req(2, 13, 27);
                wait_valid(1, 40, '0, "single");
                if (v_t.size() >= 1 && g_t.size() >= 1) begin
                    chk("single grant idx", 64'(g_idx[0]), 64'd2);
                    chk("single latency", 64'(v_t[0] - g_t[0]), 64'(LT + 1));
                    chk("single ores", 64'(v_res[0]), 64'd351);
                    chk("single oid", 64'(v_id[0]), 64'd2);
                end

                // all clients requesting, client 0 held high throughout
                do_reset();
                req(0, 31, 31); req(1, 1, 1); req(2, 0, 17); req(3, 5, 6);
                wait_valid(5, 5 * (LT + 3) + 10, 4'b0001, "all4");
                ireq = '0;
                if (v_t.size() >= 5 && g_t.size() >= 5) begin
                    for (int i = 0; i < 5; i++) begin
                        chk($sformatf("all4 grant%0d", i), 64'(g_idx[i]), 64'(exp_g[i]));
                        chk($sformatf("all4 ores%0d", i), 64'(v_res[i]), 64'(exp_r[i]));
                        chk($sformatf("all4 oid%0d", i), 64'(v_id[i]), 64'(exp_g[i]));
                        chk($sformatf("all4 lat%0d", i), 64'(v_t[i] - g_t[i]), 64'(LT + 1));
                        if (i < 4) chk($sformatf("all4 gap%0d", i), 64'(g_t[i+1] - v_t[i]), 64'd1);
                    end
                end

                // client 1 arrives during client 3's operation
                do_reset();
                req(3, 7, 9);
                repeat (3) tick(0, '0);
                req(1, 3, 4);
                wait_valid(2, 3 * (LT + 3), '0, "wait_req");
                if (v_t.size() >= 2 && g_t.size() >= 2) begin
                    chk("wait_req first", 64'(g_idx[0]), 64'd3);
                    chk("wait_req second", 64'(g_idx[1]), 64'd1);
                    chk("wait_req no gap", 64'(g_t[1] - v_t[0]), 64'd1);
                    chk("wait_req ores", 64'(v_res[1]), 64'd12);
                end

                // reset in the middle of an operation
                do_reset();
                req(0, 11, 11);
                repeat (4) tick(0, '0);
                chk("midrst busy before", 64'(obusy), 64'd1);
                irst_n = 1'b0;
                #1;
                chk("midrst obusy", 64'(obusy), 64'd0);
                chk("midrst ocore_a", 64'(ocore_a), 64'd0);
                chk("midrst ocore_start", 64'(ocore_start), 64'd0);
                chk("midrst ogrant", 64'(ogrant), 64'd0);
                ireq = '0;
                repeat (2) tick(0, '0);
                irst_n = 1'b1;
                clr_log();
                repeat (LT + 4) tick(0, '0);
                chk("midrst no ovalid", 64'(v_t.size()), 64'd0);
                req(1, 9, 9);
                wait_valid(1, LT + 6, '0, "midrst_after");
                if (v_t.size() >= 1) begin
                    chk("midrst after ores", 64'(v_res[0]), 64'd81);
                    chk("midrst after oid", 64'(v_id[0]), 64'd1);
                end

                // client 0 withdraws while the scheduler is busy
                do_reset();
                req(1, 2, 3);
                repeat (2) tick(0, '0);
                req(0, 4, 4); req(2, 5, 5);
                repeat (3) tick(0, '0);
                ireq[0] = 1'b0;
                wait_valid(2, 3 * (LT + 3), '0, "withdraw");
                zeros = 0;
                foreach (g_idx[i]) if (g_idx[i] == 0) zeros++;
                chk("withdraw client0 grants", 64'(zeros), 64'd0);
                if (g_idx.size() >= 2) chk("withdraw second", 64'(g_idx[1]), 64'd2);
                if (v_t.size() >= 2) chk("withdraw ores", 64'(v_res[1]), 64'd25);
            end else begin
                // LAT=1, two clients held continuously: strict alternation and ptr wrap
                req(0, 3, 3); req(1, 2, 7);
                wait_valid(4, 40, 2'b11, "alt");
                ireq = '0;
                if (v_t.size() >= 4 && g_t.size() >= 4) begin
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("alt grant%0d", i), 64'(g_idx[i]), 64'(i % 2));
                        chk($sformatf("alt ores%0d", i), 64'(v_res[i]), (i % 2 == 0) ? 64'd9 : 64'd14);
                        chk($sformatf("alt lat%0d", i), 64'(v_t[i] - g_t[i]), 64'(LT + 1));
                        if (i < 3) chk($sformatf("alt period%0d", i), 64'(g_t[i+1] - g_t[i]), 64'(LT + 2));
                    end
                end
            end

            do_reset();
            repeat (1500) tick(1, '0);
            ireq = '0;
            repeat (LT + 4) tick(0, '0);
            done_f = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(cfg[0].done_f && cfg[1].done_f) && t < 20000) begin
            @(posedge iclk);
            t++;
        end
        if (!(cfg[0].done_f && cfg[1].done_f)) chk("global timeout", 64'd0, 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
